// File: rtl/nes_cpu_bus_fabric_pkg.sv
// Shared types and the default NES CPU memory map for the bus fabric.
package nes_cpu_bus_fabric_pkg;

    localparam int NES_ADDR_W    = 16;
    localparam int NES_DATA_W    = 8;
    localparam int NES_N_REGIONS = 4;

    typedef logic [NES_ADDR_W-1:0] addr_t;
    typedef logic [NES_DATA_W-1:0] data_t;

    // Region 0: 2 KiB work RAM, region 1: PPU registers, region 2: APU/IO, region 3: cartridge
    localparam logic [NES_N_REGIONS-1:0][NES_ADDR_W-1:0] NES_REGION_BASE =
        {16'h4020, 16'h4000, 16'h2000, 16'h0000};
    localparam logic [NES_N_REGIONS-1:0][NES_ADDR_W-1:0] NES_REGION_LIMIT =
        {16'hFFFF, 16'h401F, 16'h3FFF, 16'h1FFF};
    localparam logic [NES_N_REGIONS-1:0][NES_ADDR_W-1:0] NES_REGION_MASK =
        {16'hFFFF, 16'h001F, 16'h0007, 16'h07FF};

    localparam addr_t NES_DMA_REG_ADDR  = 16'h4014;
    localparam addr_t NES_DMA_DEST_ADDR = 16'h2004;
    localparam int    NES_DMA_LEN       = 256;
    localparam data_t NES_OPEN_BUS_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        RD,
        WR
    } dma_state_t;

endpackage

// File: rtl/nes_cpu_bus_fabric_if.sv
// CPU-facing side of the bus fabric: address/data/direction from the CPU,
// read data, ready and DMA ownership back to it.
interface nes_cpu_bus_fabric_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw_n;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;
    logic              dma_active;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rw_n,
        input  cpu_rdata, cpu_rdy, dma_active
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw_n,
        output cpu_rdata, cpu_rdy, dma_active
    );
endinterface

// File: rtl/nes_oam_dma.sv
// OAM DMA engine: once started, halts the CPU and copies one page into the
// sprite data port, alternating a read cycle and a write cycle per byte.
//
// state | meaning
// IDLE  | waiting for a CPU write to the DMA register
// HALT  | first stall cycle, no bus traffic
// ALIGN | extra idle cycle when HALT landed on an odd cycle
// RD    | read source byte {page, idx}
// WR    | write returned byte to the destination port, advance idx
module nes_oam_dma
    import nes_cpu_bus_fabric_pkg::*;
#(
    parameter int                ADDR_W        = NES_ADDR_W,
    parameter int                DATA_W        = NES_DATA_W,
    parameter logic [ADDR_W-1:0] DMA_DEST_ADDR = NES_DMA_DEST_ADDR,
    parameter int                DMA_LEN       = NES_DMA_LEN
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              start,
    input  logic [DATA_W-1:0] start_page,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              req_en,
    output logic              req_rw_n,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t        state_q, state_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic [7:0]        idx_q, idx_d;
    logic              parity_q, parity_d;

    // Next-state logic; parity free-runs so ALIGN can be decided in HALT
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        parity_d = ~parity_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    page_d  = start_page;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT:    state_d = parity_q ? ALIGN : RD;
            ALIGN:   state_d = RD;
            RD:      state_d = WR;
            WR: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? IDLE : RD;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
        end
    end

    // Request decode straight from state; the write data is the byte the
    // fabric returns from the preceding RD cycle
    always_comb begin
        busy      = (state_q != IDLE);
        req_en    = (state_q == RD) || (state_q == WR);
        req_rw_n  = (state_q != WR);
        req_addr  = (state_q == WR) ? DMA_DEST_ADDR : ADDR_W'({page_q, idx_q});
        req_wdata = rd_data;
    end

endmodule

// File: rtl/nes_cpu_bus_fabric.sv
// CPU-side bus fabric: muxes CPU and OAM-DMA requests into one region
// decoder, drives one-hot region strobes, returns registered read data and
// keeps the open-bus latch for unmapped reads.
module nes_cpu_bus_fabric
    import nes_cpu_bus_fabric_pkg::*;
#(
    parameter int ADDR_W    = NES_ADDR_W,
    parameter int DATA_W    = NES_DATA_W,
    parameter int N_REGIONS = NES_N_REGIONS,
    parameter logic [N_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  = NES_REGION_BASE,
    parameter logic [N_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT = NES_REGION_LIMIT,
    parameter logic [N_REGIONS-1:0][ADDR_W-1:0] REGION_MASK  = NES_REGION_MASK,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
    parameter logic [ADDR_W-1:0] DMA_DEST_ADDR = NES_DMA_DEST_ADDR,
    parameter int                DMA_LEN       = NES_DMA_LEN,
    parameter logic [DATA_W-1:0] OPEN_BUS_INIT = NES_OPEN_BUS_INIT
) (
    input  logic                               CLK,
    input  logic                               RESET_n,
    nes_cpu_bus_fabric_if.slave                cpu,
    output logic [ADDR_W-1:0]                  rgn_addr,
    output logic [DATA_W-1:0]                  rgn_wdata,
    output logic [N_REGIONS-1:0]               rgn_wren,
    output logic [N_REGIONS-1:0]               rgn_rden,
    input  logic [N_REGIONS-1:0][DATA_W-1:0]   rgn_rdata
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    logic              dma_busy, dma_req_en, dma_req_rw_n, dma_start;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rw_n, bus_en, bus_fwd;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] hit_local, offset;

    logic              rd_pend_q, rd_pend_d;
    logic              rd_unm_q, rd_unm_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] ob_q, ob_d;
    logic [DATA_W-1:0] rdata_mux;

    // A CPU write to the DMA register is swallowed here and kicks the engine
    assign dma_start = !dma_busy && !cpu.cpu_rw_n && (cpu.cpu_addr == DMA_REG_ADDR);

    nes_oam_dma #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .DMA_DEST_ADDR (DMA_DEST_ADDR),
        .DMA_LEN       (DMA_LEN)
    ) u_dma (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .start      (dma_start),
        .start_page (cpu.cpu_wdata),
        .rd_data    (rdata_mux),
        .busy       (dma_busy),
        .req_en     (dma_req_en),
        .req_rw_n   (dma_req_rw_n),
        .req_addr   (dma_req_addr),
        .req_wdata  (dma_req_wdata)
    );

    // Bus owner select: the DMA engine takes over completely while busy
    always_comb begin
        if (dma_busy) begin
            bus_addr  = dma_req_addr;
            bus_wdata = dma_req_wdata;
            bus_rw_n  = dma_req_rw_n;
            bus_en    = dma_req_en;
        end else begin
            bus_addr  = cpu.cpu_addr;
            bus_wdata = cpu.cpu_wdata;
            bus_rw_n  = cpu.cpu_rw_n;
            bus_en    = 1'b1;
        end
        bus_fwd = bus_en && !dma_start;
    end

    // Region decode, lowest index wins; the modulo offset doubles as the
    // range test so base 0 needs no special case
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        hit_local = '0;
        offset    = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            offset = bus_addr - REGION_BASE[i];
            if (offset <= (REGION_LIMIT[i] - REGION_BASE[i])) begin
                hit       = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_local = offset & REGION_MASK[i];
            end
        end
    end

    // Region-side outputs; strobes are held off while reset is asserted
    always_comb begin
        rgn_addr  = hit ? hit_local : bus_addr;
        rgn_wdata = bus_wdata;
        rgn_wren  = '0;
        rgn_rden  = '0;
        if (RESET_n && bus_fwd && hit) begin
            if (bus_rw_n) rgn_rden[hit_idx] = 1'b1;
            else          rgn_wren[hit_idx] = 1'b1;
        end
    end

    // Read return and open-bus update; a write in the same cycle as a
    // completing read is the newer value and wins
    always_comb begin
        rdata_mux = rd_unm_q ? ob_q : rgn_rdata[rd_idx_q];
        rd_pend_d = bus_en && bus_rw_n;
        rd_unm_d  = rd_unm_q;
        rd_idx_d  = rd_idx_q;
        if (bus_en && bus_rw_n) begin
            rd_unm_d = !hit;
            rd_idx_d = hit_idx;
        end
        ob_d = ob_q;
        if (rd_pend_q && !rd_unm_q) ob_d = rdata_mux;
        if (bus_en && !bus_rw_n)    ob_d = bus_wdata;
    end

    // Read-return tracking and open-bus latch
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rd_pend_q <= 1'b0;
            rd_unm_q  <= 1'b1;
            rd_idx_q  <= '0;
            ob_q      <= OPEN_BUS_INIT;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_unm_q  <= rd_unm_d;
            rd_idx_q  <= rd_idx_d;
            ob_q      <= ob_d;
        end
    end

    assign cpu.cpu_rdata  = rdata_mux;
    assign cpu.cpu_rdy    = !dma_busy;
    assign cpu.dma_active = dma_busy;

endmodule

// File: tb/tb_nes_cpu_bus_fabric.sv
// Scoreboard bench for the CPU bus fabric: stimulus pushes expected strobes,
// read data and stall lengths; a negedge monitor pops and compares them.
module tb_nes_cpu_bus_fabric;
    import nes_cpu_bus_fabric_pkg::*;

    localparam logic [3:0][15:0] T_BASE  = {16'h4020, 16'h4000, 16'h0000, 16'h0000};
    localparam logic [3:0][15:0] T_LIMIT = {16'h4FFF, 16'h401F, 16'h3FFF, 16'h1FFF};
    localparam logic [3:0][15:0] T_MASK  = {16'hFFFF, 16'h001F, 16'h0007, 16'h07FF};

    logic CLK = 1'b0;
    logic RESET_n;
    addr_t            rgn_addr;
    data_t            rgn_wdata;
    logic [3:0]       rgn_wren, rgn_rden;
    logic [3:0][7:0]  rgn_rdata;

    nes_cpu_bus_fabric_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    nes_cpu_bus_fabric #(
        .REGION_BASE  (T_BASE),
        .REGION_LIMIT (T_LIMIT),
        .REGION_MASK  (T_MASK)
    ) dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .cpu       (bus),
        .rgn_addr  (rgn_addr),
        .rgn_wdata (rgn_wdata),
        .rgn_wren  (rgn_wren),
        .rgn_rden  (rgn_rden),
        .rgn_rdata (rgn_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] wren;
        logic [3:0] rden;
        addr_t      addr;
        data_t      wdata;
    } strb_t;
    typedef struct {
        int    cyc;
        data_t data;
    } rd_t;

    strb_t strb_q[$];
    rd_t   rd_q[$];
    int    stall_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    stall_cnt = 0;
    logic  m_par;

    function automatic data_t rdfn(int i, addr_t a);
        return a[7:0] ^ (8'h5B + 8'(i));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Region memories: 1-cycle read latency
    always @(posedge CLK)
        for (int i = 0; i < 4; i++)
            if (rgn_rden[i]) rgn_rdata[i] <= rdfn(i, rgn_addr);

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or negedge RESET_n)
        if (!RESET_n) m_par <= 1'b0;
        else          m_par <= ~m_par;

    // Monitor
    always @(negedge CLK) begin
        check("dma_active", {31'd0, bus.dma_active}, {31'd0, !bus.cpu_rdy});
        if ((rgn_rden | rgn_wren) != 4'd0) begin
            if (strb_q.size() == 0) begin
                check("unexpected_strobe", {rgn_wren, rgn_rden, rgn_addr, 8'h00}, 32'd0);
            end else begin
                strb_t e;
                e = strb_q.pop_front();
                check("strobe", {rgn_wren, rgn_rden, rgn_addr, (rgn_wren != 4'd0) ? rgn_wdata : 8'h00},
                      {e.wren, e.rden, e.addr, e.wdata});
            end
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            void'(rd_q.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL rdata_missed: expected read return not sampled (cycle %0d)", cyc);
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            rd_t r;
            r = rd_q.pop_front();
            check("rdata", {24'd0, bus.cpu_rdata}, {24'd0, r.data});
        end
        if (!bus.cpu_rdy) begin
            stall_cnt++;
        end else if (stall_cnt != 0) begin
            if (stall_q.size() == 0) check("unexpected_stall", stall_cnt, 0);
            else                     check("stall_len", stall_cnt, stall_q.pop_front());
            stall_cnt = 0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rw_n, input addr_t a, input data_t d);
        bus.cpu_rw_n  = rw_n;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic idle(input int n);
        drive(1'b1, 16'h5000, 8'h00);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd(input addr_t a, input int r, input addr_t loc, input data_t d);
        drive(1'b1, a, 8'h00);
        if (r >= 0) strb_q.push_back('{wren: 4'd0, rden: 4'b0001 << r, addr: loc, wdata: 8'h00});
        rd_q.push_back('{cyc: cyc + 1, data: d});
        step();
    endtask

    task automatic wr(input addr_t a, input data_t d, input int r, input addr_t loc);
        drive(1'b0, a, d);
        if (r >= 0) strb_q.push_back('{wren: 4'b0001 << r, rden: 4'd0, addr: loc, wdata: d});
        step();
    endtask

    // Expected RD/WR strobe pairs for the first nb bytes of a page in region 0
    task automatic push_dma(input data_t page, input int nb);
        for (int k = 0; k < nb; k++) begin
            addr_t loc;
            loc = {page, 8'(k)} & 16'h07FF;
            strb_q.push_back('{wren: 4'd0, rden: 4'b0001, addr: loc, wdata: 8'h00});
            strb_q.push_back('{wren: 4'b0010, rden: 4'd0, addr: 16'h0004, wdata: rdfn(0, loc)});
        end
    endtask

    task automatic wait_rdy(input int budget);
        int k;
        k = 0;
        drive(1'b1, 16'h5000, 8'h00);
        while (!bus.cpu_rdy && k < budget) begin
            step();
            k++;
        end
        if (!bus.cpu_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_rdy: cpu_rdy still low after %0d cycles", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        drive(1'b1, 16'h5000, 8'h00);
        RESET_n = 1'b1;
        #2 RESET_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_strobes", {24'd0, rgn_wren, rgn_rden}, 32'd0);
        @(posedge CLK);
        #1 RESET_n = 1'b1;
        check("reset_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        check("reset_dma_active", {31'd0, bus.dma_active}, 32'd0);
        check("reset_rdata", {24'd0, bus.cpu_rdata}, 32'h00);
        idle(1);

        // decode, mirroring and read return
        rd(16'h0801, 0, 16'h0001, 8'h5A);
        rd(16'h1801, 0, 16'h0001, 8'h5A);
        wr(16'h3FFE, 8'h3C, 1, 16'h0006);
        rd(16'h5000, -1, 16'h0000, 8'h3C);
        rd(16'h4015, 2, 16'h0015, 8'h48);
        rd(16'h4123, 3, 16'h0103, 8'h5D);
        rd(16'hFFFF, -1, 16'h0000, 8'h5D);
        wr(16'h4000, 8'h77, 2, 16'h0000);
        rd(16'h5000, -1, 16'h0000, 8'h77);
        rd(16'h0010, 0, 16'h0010, 8'h4B);
        idle(2);

        // DMA with HALT on an even cycle: 513-cycle stall
        if (m_par !== 1'b1) idle(1);
        push_dma(8'h02, 256);
        stall_q.push_back(513);
        wr(16'h4014, 8'h02, -1, 16'h0000);
        wait_rdy(700);
        rd(16'h5000, -1, 16'h0000, 8'hA4);
        idle(2);

        // DMA with HALT on an odd cycle: ALIGN inserted, 514-cycle stall
        if (m_par !== 1'b0) idle(1);
        push_dma(8'h05, 256);
        stall_q.push_back(514);
        wr(16'h4014, 8'h05, -1, 16'h0000);
        wait_rdy(700);
        rd(16'hFFFF, -1, 16'h0000, 8'hA4);
        idle(2);

        // Reset while the read of byte 100 is on the bus
        a = (m_par == 1'b0) ? 1 : 0;
        push_dma(8'h02, 100);
        stall_q.push_back(1 + a + 200);
        wr(16'h4014, 8'h02, -1, 16'h0000);
        idle(201 + a);
        check("rdy_before_abort", {31'd0, bus.cpu_rdy}, 32'd0);
        RESET_n = 1'b0;
        #1;
        check("abort_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        check("abort_dma_active", {31'd0, bus.dma_active}, 32'd0);
        check("abort_strobes", {24'd0, rgn_wren, rgn_rden}, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #1 RESET_n = 1'b1;
        rd(16'h5000, -1, 16'h0000, 8'h00);
        rd(16'h0801, 0, 16'h0001, 8'h5A);
        idle(3);

        check("strobe_queue_empty", strb_q.size(), 0);
        check("rdata_queue_empty", rd_q.size(), 0);
        check("stall_queue_empty", stall_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
